rst_req_ctrl: RTL and testbench

RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

---
 rtl/rst_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_rst_req_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset request controller: merges a debounced push-button, a watchdog and a
// software strobe into one fixed-length active-low reset request with cooldown.
module rst_req_ctrl #(
  parameter int DEB_W     = 20,
  parameter int WDT_W     = 26,
  parameter int PULSE_LEN = 16
) (
  input  logic       CLK,
  input  logic       RST_X_I,
  input  logic       BTN_X,
  input  logic       SW_RST,
  input  logic       WDT_EN,
  input  logic       WDT_KICK,
  output logic       RST_REQ_X_O,
  output logic [1:0] CAUSE,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_COOL   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  // Counter would reach all-ones on this edge: that is the accepting edge.
  localparam logic [DEB_W-1:0] DEB_LAST = {DEB_W{1'b1}} - DEB_ONE;
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
  localparam logic [WDT_W-1:0] WDT_MAX  = {WDT_W{1'b1}};
  localparam logic [7:0]       PH_LAST  = 8'(PULSE_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  state_t           state_q, state_d;
  logic [7:0]       phase_q, phase_d;
  logic [1:0]       cause_q, cause_d;
  logic             rst_req_q, rst_req_d;
  logic             busy_q, busy_d;

  logic btn_evt, wdt_evt, sw_evt, wdt_run, in_idle;

  // BTN_X is asynchronous to CLK; two flops before anything looks at it.
  always_ff @(posedge CLK or negedge RST_X_I) begin
    if (!RST_X_I) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= BTN_X;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end
  end

  // Only the press edge is an event; release is debounced silently.
  assign btn_evt = deb_q & ~deb_d;

  assign in_idle = (state_q == S_IDLE);
  assign wdt_run = WDT_EN & ~WDT_KICK & in_idle;
  assign wdt_evt = wdt_run & (wdt_cnt_q == WDT_MAX);
  assign wdt_cnt_d = wdt_run ? (wdt_cnt_q + WDT_ONE) : '0;
  assign sw_evt  = SW_RST & in_idle;

  always_ff @(posedge CLK or negedge RST_X_I) begin
    if (!RST_X_I) begin
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      wdt_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      wdt_cnt_q <= wdt_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (btn_evt || wdt_evt || sw_evt) begin
          state_d = S_ASSERT;
          phase_d = 8'd0;
          if (btn_evt)      cause_d = CAUSE_BTN;
          else if (wdt_evt) cause_d = CAUSE_WDT;
          else              cause_d = CAUSE_SW;
        end
      end
      S_ASSERT: begin
        if (phase_q == PH_LAST) begin
          state_d = S_COOL;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_COOL: begin
        if (phase_q == PH_LAST) begin
          state_d = S_IDLE;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are pure flop outputs.
  assign rst_req_d = (state_d != S_ASSERT);
  assign busy_d    = (state_d != S_IDLE);

  always_ff @(posedge CLK or negedge RST_X_I) begin
    if (!RST_X_I) begin
      state_q   <= S_IDLE;
      phase_q   <= 8'd0;
      cause_q   <= CAUSE_NONE;
      rst_req_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cause_q   <= cause_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
    end
  end

  assign RST_REQ_X_O = rst_req_q;
  assign CAUSE       = cause_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Scoreboard bench for rst_req_ctrl: stimulus queues expected pulses, a
// negedge monitor measures each observed request/busy window and compares.
module tb_rst_req_ctrl;
  localparam int DEB_W     = 4;
  localparam int WDT_W     = 6;
  localparam int PULSE_LEN = 8;

  logic       CLK      = 1'b0;
  logic       RST_X_I  = 1'b1;
  logic       BTN_X    = 1'b1;
  logic       SW_RST   = 1'b0;
  logic       WDT_EN   = 1'b0;
  logic       WDT_KICK = 1'b0;
  logic       RST_REQ_X_O;
  logic [1:0] CAUSE;
  logic       BUSY;

  rst_req_ctrl #(
    .DEB_W(DEB_W), .WDT_W(WDT_W), .PULSE_LEN(PULSE_LEN)
  ) dut (
    .CLK(CLK), .RST_X_I(RST_X_I), .BTN_X(BTN_X), .SW_RST(SW_RST),
    .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
    .RST_REQ_X_O(RST_REQ_X_O), .CAUSE(CAUSE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int start;
    int len;
    int blen;
    int cause;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  task automatic push(input int start, input int len, input int blen, input int cause);
    exp_t e;
    e.start = start; e.len = len; e.blen = blen; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a request window ends when BUSY drops.
  initial begin
    bit   in_p = 0;
    bit   in_b = 0;
    int   p_start = 0, p_len = 0, b_len = 0, p_cause = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_REQ_X_O === 1'b0) begin
        if (!in_p) begin
          in_p = 1; p_start = cyc; p_cause = int'(CAUSE); p_len = 0;
        end
        p_len++;
      end else begin
        in_p = 0;
      end
      if (BUSY === 1'b1) begin
        in_b = 1;
        b_len++;
      end else if (in_b) begin
        in_b = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: start %0d cause %0d, expected no pulse", p_start, p_cause);
        end else begin
          e = exp_q.pop_front();
          check("pulse_start", p_start, e.start);
          check("pulse_len", p_len, e.len);
          check("busy_len", b_len, e.blen);
          check("pulse_cause", p_cause, e.cause);
        end
        b_len = 0;
      end
    end
  end

  initial begin
    int c;
    #1 RST_X_I = 1'b0;
    #2;
    check("reset_req", int'(RST_REQ_X_O), 1);
    check("reset_cause", int'(CAUSE), 0);
    check("reset_busy", int'(BUSY), 0);
    repeat (3) tick();
    RST_X_I = 1'b1;
    repeat (5) tick();

    // Software strobe
    c = cyc;
    SW_RST = 1'b1;
    push(c + 1, 8, 16, 3);
    tick();
    SW_RST = 1'b0;
    repeat (25) tick();
    check("cause_sticky_sw", int'(CAUSE), 3);

    // Button glitches of 10 and 14 cycles are rejected
    BTN_X = 1'b0;
    repeat (10) tick();
    BTN_X = 1'b1;
    repeat (25) tick();
    BTN_X = 1'b0;
    repeat (14) tick();
    BTN_X = 1'b1;
    repeat (25) tick();

    // Shortest accepted press: 15 cycles
    c = cyc;
    BTN_X = 1'b0;
    push(c + 17, 8, 16, 1);
    repeat (15) tick();
    BTN_X = 1'b1;
    repeat (40) tick();

    // Held press of 40 cycles gives one pulse
    c = cyc;
    BTN_X = 1'b0;
    push(c + 17, 8, 16, 1);
    repeat (40) tick();
    BTN_X = 1'b1;
    repeat (40) tick();

    // Watchdog timeout
    c = cyc;
    WDT_EN = 1'b1;
    push(c + 64, 8, 16, 2);
    repeat (66) tick();
    WDT_EN = 1'b0;
    repeat (20) tick();

    // Watchdog kicked every 50 cycles for 1000 cycles
    WDT_EN = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      WDT_KICK = (i % 50 == 49);
      tick();
    end
    WDT_KICK = 1'b0;
    WDT_EN   = 1'b0;
    repeat (5) tick();

    // Software and watchdog coincide; later software strobe during COOL
    c = cyc;
    WDT_EN = 1'b1;
    push(c + 64, 8, 16, 2);
    repeat (63) tick();
    SW_RST = 1'b1;
    tick();
    SW_RST = 1'b0;
    WDT_EN = 1'b0;
    repeat (10) tick();
    SW_RST = 1'b1;
    tick();
    SW_RST = 1'b0;
    repeat (30) tick();
    check("cause_after_cool_sw", int'(CAUSE), 2);

    // Board reset in the third ASSERT cycle
    c = cyc;
    SW_RST = 1'b1;
    push(c + 1, 3, 3, 3);
    tick();
    SW_RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("third_assert_cycle_req", int'(RST_REQ_X_O), 0);
    @(negedge CLK);
    #1 RST_X_I = 1'b0;
    #1;
    check("midreset_req", int'(RST_REQ_X_O), 1);
    check("midreset_cause", int'(CAUSE), 0);
    check("midreset_busy", int'(BUSY), 0);
    repeat (3) @(posedge CLK);
    #1 RST_X_I = 1'b1;
    repeat (60) tick();
    check("post_release_req", int'(RST_REQ_X_O), 1);
    check("post_release_cause", int'(CAUSE), 0);

    check("pending_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
